// File: rtl/pgm_ddram_rd_bridge.sv
// pgm_ddram_rd_bridge
//
// Purpose:
//   Responder for the video engine's graphics-ROM read port. Single 64-bit
//   word reads are answered from a one-line read cache. On a miss, the whole
//   aligned line is fetched as one burst from the DDR3 Avalon-style port.
//   The cache hides DDR latency for sequential sprite fetches.
//
// Ports:
//   clk               system clock
//   reset             synchronous, active-high reset
//   ddram_rd          client read request
//   ddram_addr        client 64-bit word address
//   ddram_busy        bridge cannot accept a request this cycle
//   ddram_dout        read data (holds between responses)
//   ddram_dout_valid  one-cycle strobe, ddram_dout valid
//   flush             invalidate the cached line
//   mem_rd            DDR read command
//   mem_addr          DDR word address, line aligned
//   mem_burstcnt      DDR burst length (LINE_WORDS)
//   mem_busy          DDR waitrequest
//   mem_dout          DDR read beat data
//   mem_dout_ready    DDR read beat valid
//   mem_we/mem_be/mem_din  write side, tied off (read-only bridge)

module pgm_ddram_rd_bridge #(
  parameter int LINE_WORDS = 4,
  parameter int LW         = $clog2(LINE_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ddram_rd,
  input  logic [28:0] ddram_addr,
  output logic        ddram_busy,
  output logic [63:0] ddram_dout,
  output logic        ddram_dout_valid,
  input  logic        flush,
  output logic        mem_rd,
  output logic [28:0] mem_addr,
  output logic [7:0]  mem_burstcnt,
  input  logic        mem_busy,
  input  logic [63:0] mem_dout,
  input  logic        mem_dout_ready,
  output logic        mem_we,
  output logic [7:0]  mem_be,
  output logic [63:0] mem_din
);

  // Offset counters need at least one bit even when a line is a single word.
  localparam int              OFFW      = (LW > 0) ? LW : 1;
  localparam logic [28:0]     OFF_MASK  = 29'(LINE_WORDS - 1);
  localparam logic [OFFW-1:0] LAST_BEAT = OFFW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_FILL,
    ST_RESP
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [63:0]     r_line [LINE_WORDS];
  // The tag is kept as the line base address (low offset bits zero). This is
  // equivalent to storing addr[28:LW], and it compares without shifting.
  logic [28:0]     r_tag;
  logic            r_valid;
  logic [OFFW-1:0] r_beat;
  logic [28:0]     r_reqAddr;
  logic            r_flushSeen;

  logic            r_busy;
  logic [63:0]     r_dout;
  logic            r_doutValid;
  logic            r_memRd;
  logic [28:0]     r_memAddr;
  logic [7:0]      r_memBurstcnt;

  logic            w_accept;
  logic            w_hit;
  logic            w_cmdTaken;
  logic            w_beatIn;
  logic            w_lastBeat;
  logic [OFFW-1:0] w_reqOff;
  logic [OFFW-1:0] w_heldOff;
  logic [28:0]     w_lineBase;

  assign w_lineBase = ddram_addr & ~OFF_MASK;
  assign w_reqOff   = OFFW'(ddram_addr & OFF_MASK);
  assign w_heldOff  = OFFW'(r_reqAddr & OFF_MASK);
  assign w_accept   = ddram_rd && !r_busy && (r_state == ST_IDLE);
  assign w_hit      = r_valid && (w_lineBase == r_tag);
  assign w_cmdTaken = (r_state == ST_ISSUE) && r_memRd && !mem_busy;
  assign w_beatIn   = (r_state == ST_FILL) && mem_dout_ready;
  assign w_lastBeat = (r_beat == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Beats that arrive outside FILL are dropped. This is what makes stray
  // beats harmless after a reset that interrupted a burst.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_nextState = w_hit ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_cmdTaken) begin
          w_nextState = ST_FILL;
        end
      end
      ST_FILL: begin
        if (mem_dout_ready && w_lastBeat) begin
          w_nextState = ST_RESP;
        end
      end
      ST_RESP: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // The line storage has no reset. Nothing is read from it until the valid
  // bit is set, or until the beats of the current fill have written it.
  always_ff @(posedge clk) begin
    if (w_beatIn) begin
      r_line[r_beat] <= mem_dout;
    end
  end

  // Request, DDR command and response registers.
  // A flush seen at any point during the fill is remembered in r_flushSeen.
  // This stops the completed fill from re-validating stale ROM contents,
  // while the requested word is still returned.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag         <= '0;
      r_valid       <= 1'b0;
      r_beat        <= '0;
      r_reqAddr     <= '0;
      r_flushSeen   <= 1'b0;
      r_busy        <= 1'b0;
      r_dout        <= '0;
      r_doutValid   <= 1'b0;
      r_memRd       <= 1'b0;
      r_memAddr     <= '0;
      r_memBurstcnt <= 8'(LINE_WORDS);
    end else begin
      r_doutValid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_busy      <= 1'b1;
            r_reqAddr   <= ddram_addr;
            r_flushSeen <= flush;
            if (w_hit) begin
              r_dout      <= r_line[w_reqOff];
              r_doutValid <= 1'b1;
            end else begin
              r_memRd       <= 1'b1;
              r_memAddr     <= w_lineBase;
              r_memBurstcnt <= 8'(LINE_WORDS);
            end
          end
        end
        ST_ISSUE: begin
          if (flush) begin
            r_flushSeen <= 1'b1;
          end
          if (w_cmdTaken) begin
            r_memRd <= 1'b0;
            r_beat  <= '0;
          end
        end
        ST_FILL: begin
          if (flush) begin
            r_flushSeen <= 1'b1;
          end
          if (mem_dout_ready) begin
            r_beat <= r_beat + 1'b1;
            if (w_lastBeat) begin
              r_tag       <= r_reqAddr & ~OFF_MASK;
              r_doutValid <= 1'b1;
              // The last beat is only being written this cycle, so it
              // bypasses the line storage.
              if (w_heldOff == LAST_BEAT) begin
                r_dout <= mem_dout;
              end else begin
                r_dout <= r_line[w_heldOff];
              end
            end
          end
        end
        ST_RESP: begin
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase

      // Valid bit: flush always wins. A miss invalidates the line at once.
      // A fill with no flush seen validates it on the last beat.
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept && !w_hit) begin
        r_valid <= 1'b0;
      end else if (w_beatIn && w_lastBeat && !r_flushSeen) begin
        r_valid <= 1'b1;
      end
    end
  end

  assign ddram_busy       = r_busy;
  assign ddram_dout       = r_dout;
  assign ddram_dout_valid = r_doutValid;
  assign mem_rd           = r_memRd;
  assign mem_addr         = r_memAddr;
  assign mem_burstcnt     = r_memBurstcnt;
  assign mem_we           = 1'b0;
  assign mem_be           = 8'hFF;
  assign mem_din          = 64'd0;

endmodule

// File: tb/tb_pgm_ddram_rd_bridge.sv
// tb_pgm_ddram_rd_bridge
//
// Purpose:
//   Self-checking bench for pgm_ddram_rd_bridge with LINE_WORDS=4.
//   - Read data is checked by a scoreboard. On every accepted request, the
//     word the memory model holds at that address is queued. Each valid
//     strobe pops and compares one entry.
//   - Hit/miss behaviour and DDR command fields come from a vector table.
//   - Multi-cycle corner cases are hand-written sequences: waitrequest,
//     flush during a fill, flush on a hit, request pulses while busy, and
//     reset during a fill.

module tb_pgm_ddram_rd_bridge;

  localparam int LINE_WORDS = 4;

  logic        clk;
  logic        reset;
  logic        ddram_rd;
  logic [28:0] ddram_addr;
  logic        ddram_busy;
  logic [63:0] ddram_dout;
  logic        ddram_dout_valid;
  logic        flush;
  logic        mem_rd;
  logic [28:0] mem_addr;
  logic [7:0]  mem_burstcnt;
  logic        mem_busy;
  logic [63:0] mem_dout;
  logic        mem_dout_ready;
  logic        mem_we;
  logic [7:0]  mem_be;
  logic [63:0] mem_din;

  int checks = 0;
  int errors = 0;
  int strobeCount = 0;
  int cmdCount = 0;
  logic [63:0] expQ[$];

  typedef struct {
    logic [28:0] addr;
    logic        expHit;
    logic [28:0] expMemAddr;
    int          gapLen;
  } vec_t;

  vec_t vecs[9];

  pgm_ddram_rd_bridge #(.LINE_WORDS(LINE_WORDS)) dut (
    .clk              (clk),
    .reset            (reset),
    .ddram_rd         (ddram_rd),
    .ddram_addr       (ddram_addr),
    .ddram_busy       (ddram_busy),
    .ddram_dout       (ddram_dout),
    .ddram_dout_valid (ddram_dout_valid),
    .flush            (flush),
    .mem_rd           (mem_rd),
    .mem_addr         (mem_addr),
    .mem_burstcnt     (mem_burstcnt),
    .mem_busy         (mem_busy),
    .mem_dout         (mem_dout),
    .mem_dout_ready   (mem_dout_ready),
    .mem_we           (mem_we),
    .mem_be           (mem_be),
    .mem_din          (mem_din)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of the DDR memory model. The pattern is unique per address.
  function automatic logic [63:0] memData(input logic [28:0] a);
    return {3'b101, a, 3'b010, ~a};
  endfunction

  // Compares one value and prints a FAIL line on a difference.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Advances one clock. Outputs are sampled 1 unit after the edge, and
  // inputs driven from here are stable well before the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and event counters. They sample on the falling edge, away
  // from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (ddram_rd && !ddram_busy) begin
        expQ.push_back(memData(ddram_addr));
      end
      if (mem_rd && !mem_busy) begin
        cmdCount++;
      end
      if (ddram_dout_valid) begin
        strobeCount++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected strobe", 64'd1, 64'd0);
        end else begin
          checkOutput("scoreboard dout", ddram_dout, expQ.pop_front());
        end
      end
    end
  end

  // Presents a single-cycle read request.
  task automatic issueRead(input logic [28:0] addr, input logic flushNow);
    ddram_rd   = 1'b1;
    ddram_addr = addr;
    flush      = flushNow;
    step();
    ddram_rd = 1'b0;
    flush    = 1'b0;
  endtask

  // Returns the beats of a line. gapLen idle cycles follow beat 1.
  // flushAfter >= 0 pulses flush for one cycle after that beat.
  task automatic sendBeats(input logic [28:0] lineAddr, input int gapLen,
                           input int flushAfter, input int nBeats);
    for (int b = 0; b < nBeats; b++) begin
      mem_dout_ready = 1'b1;
      mem_dout       = memData(lineAddr + 29'(b));
      step();
      mem_dout_ready = 1'b0;
      mem_dout       = '0;
      if (b == flushAfter) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
      end
      if (b == 1) begin
        repeat (gapLen) step();
      end
    end
  endtask

  // Completes a miss whose command is on mem_rd with mem_busy low.
  task automatic finishMiss(input logic [28:0] lineAddr, input int gapLen,
                            input int flushAfter);
    int s0;
    s0 = strobeCount;
    step();
    checkOutput("mem_rd dropped after command", mem_rd, 0);
    checkOutput("busy during fill", ddram_busy, 1);
    sendBeats(lineAddr, gapLen, flushAfter, LINE_WORDS);
    checkOutput("strobe 1 cycle after last beat", ddram_dout_valid, 1);
    checkOutput("busy in response cycle", ddram_busy, 1);
    step();
    checkOutput("busy cleared after response", ddram_busy, 0);
    checkOutput("strobe one cycle only", ddram_dout_valid, 0);
    checkOutput("strobes per miss", 64'(strobeCount - s0), 1);
  endtask

  // Applies one table vector: a request, then a hit or miss as expected.
  task automatic applyStimulus(input vec_t v);
    issueRead(v.addr, 1'b0);
    checkOutput("mem_rd after accept", mem_rd, !v.expHit);
    checkOutput("busy after accept", ddram_busy, 1);
    if (v.expHit) begin
      checkOutput("hit strobe 1 cycle after accept", ddram_dout_valid, 1);
      step();
      checkOutput("hit busy cleared", ddram_busy, 0);
      checkOutput("hit strobe cleared", ddram_dout_valid, 0);
    end else begin
      checkOutput("miss mem_addr", mem_addr, v.expMemAddr);
      checkOutput("miss burstcnt", mem_burstcnt, LINE_WORDS);
      checkOutput("miss no early strobe", ddram_dout_valid, 0);
      finishMiss(v.expMemAddr, v.gapLen, -1);
    end
  endtask

  initial begin
    int c0;
    int s0;

    vecs[0] = '{addr: 29'h0400005, expHit: 1'b0, expMemAddr: 29'h0400004, gapLen: 2};
    vecs[1] = '{addr: 29'h0400007, expHit: 1'b1, expMemAddr: 29'h0, gapLen: 0};
    vecs[2] = '{addr: 29'h0400004, expHit: 1'b1, expMemAddr: 29'h0, gapLen: 0};
    vecs[3] = '{addr: 29'h0400008, expHit: 1'b0, expMemAddr: 29'h0400008, gapLen: 0};
    vecs[4] = '{addr: 29'h040000B, expHit: 1'b1, expMemAddr: 29'h0, gapLen: 0};
    vecs[5] = '{addr: 29'h0400006, expHit: 1'b0, expMemAddr: 29'h0400004, gapLen: 1};
    vecs[6] = '{addr: 29'h0000000, expHit: 1'b0, expMemAddr: 29'h0000000, gapLen: 0};
    vecs[7] = '{addr: 29'h1FFFFFFF, expHit: 1'b0, expMemAddr: 29'h1FFFFFFC, gapLen: 3};
    vecs[8] = '{addr: 29'h1FFFFFFC, expHit: 1'b1, expMemAddr: 29'h0, gapLen: 0};

    reset          = 1'b1;
    ddram_rd       = 1'b0;
    ddram_addr     = '0;
    flush          = 1'b0;
    mem_busy       = 1'b0;
    mem_dout       = '0;
    mem_dout_ready = 1'b0;

    // Reset state after three reset cycles.
    repeat (3) step();
    reset = 1'b0;
    checkOutput("reset ddram_busy", ddram_busy, 0);
    checkOutput("reset ddram_dout", ddram_dout, 0);
    checkOutput("reset ddram_dout_valid", ddram_dout_valid, 0);
    checkOutput("reset mem_rd", mem_rd, 0);
    checkOutput("reset mem_addr", mem_addr, 0);
    checkOutput("reset mem_burstcnt", mem_burstcnt, 8'd4);
    checkOutput("mem_be", mem_be, 8'hFF);
    checkOutput("mem_we", mem_we, 0);
    checkOutput("mem_din", mem_din, 0);
    step();

    // Table-driven hits and misses.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      step();
    end

    // Waitrequest: the command is held stable for 5 busy cycles.
    c0 = cmdCount;
    issueRead(29'h0000013, 1'b0);
    mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("wait mem_rd held", mem_rd, 1);
      checkOutput("wait mem_addr held", mem_addr, 29'h0000010);
      checkOutput("wait burstcnt held", mem_burstcnt, 8'd4);
    end
    mem_busy = 1'b0;
    finishMiss(29'h0000010, 0, -1);
    checkOutput("wait exactly one command", 64'(cmdCount - c0), 1);
    step();

    // Flush during a fill: the word is still returned, but the line is
    // not cached, so a re-request misses again.
    issueRead(29'h0000031, 1'b0);
    checkOutput("flush-fill miss", mem_rd, 1);
    finishMiss(29'h0000030, 0, 1);
    step();
    issueRead(29'h0000032, 1'b0);
    checkOutput("re-request after flush misses", mem_rd, 1);
    checkOutput("re-request mem_addr", mem_addr, 29'h0000030);
    finishMiss(29'h0000030, 0, -1);
    step();

    // Requests every cycle while busy: only the first one is accepted.
    c0 = cmdCount;
    s0 = strobeCount;
    ddram_rd   = 1'b1;
    ddram_addr = 29'h0000023;
    step();
    checkOutput("pulse first accepted", mem_rd, 1);
    ddram_addr = 29'h0001000;
    step();
    for (int b = 0; b < LINE_WORDS; b++) begin
      ddram_addr     = 29'h0002000 + 29'(b * 8);
      mem_dout_ready = 1'b1;
      mem_dout       = memData(29'h0000020 + 29'(b));
      step();
    end
    mem_dout_ready = 1'b0;
    checkOutput("pulse strobe", ddram_dout_valid, 1);
    ddram_rd = 1'b0;
    repeat (3) step();
    checkOutput("pulse single command", 64'(cmdCount - c0), 1);
    checkOutput("pulse single strobe", 64'(strobeCount - s0), 1);

    // Flush together with a hit: served from the line, then invalid.
    issueRead(29'h0000022, 1'b1);
    checkOutput("flush-hit no command", mem_rd, 0);
    checkOutput("flush-hit strobe", ddram_dout_valid, 1);
    step();
    step();
    issueRead(29'h0000021, 1'b0);
    checkOutput("after flush-hit misses", mem_rd, 1);
    finishMiss(29'h0000020, 0, -1);
    step();

    // Reset in the middle of a fill: the pending response is lost.
    s0 = strobeCount;
    issueRead(29'h0000041, 1'b0);
    step();
    sendBeats(29'h0000040, 0, -1, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    expQ.delete();
    checkOutput("reset-fill mem_rd", mem_rd, 0);
    checkOutput("reset-fill busy", ddram_busy, 0);
    checkOutput("reset-fill strobe", ddram_dout_valid, 0);
    mem_dout_ready = 1'b1;
    mem_dout       = memData(29'h0000042);
    step();
    mem_dout = memData(29'h0000043);
    step();
    mem_dout_ready = 1'b0;
    repeat (3) step();
    checkOutput("reset-fill no strobe", 64'(strobeCount - s0), 0);
    checkOutput("stray beats keep idle", ddram_busy, 0);
    issueRead(29'h0000042, 1'b0);
    checkOutput("post-reset miss", mem_rd, 1);
    checkOutput("post-reset mem_addr", mem_addr, 29'h0000040);
    finishMiss(29'h0000040, 0, -1);
    step();

    checkOutput("scoreboard drained", 64'(expQ.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
